// File: rtl/fifo_arbiter_4x1_pkg.sv
// fifo_arbiter_4x1_pkg: shared widths, state encodings and a one-hot to index helper.
package fifo_arbiter_4x1_pkg;
  localparam int DW  = 12;
  localparam int NIN = 4;
  localparam int TW  = 3;
  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;
  function automatic logic [1:0] oh2idx(input logic [NIN-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/fifo_arbiter_4x1_rr.sv
// rr_select_4: combinational round-robin pick of the first requester at or after ptr.
module rr_select_4
  import fifo_arbiter_4x1_pkg::*;
(
  input  logic [NIN-1:0] req,
  input  logic [1:0]     ptr,
  output logic [NIN-1:0] gnt,
  output logic           valid
);
  logic [1:0] idx;
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NIN - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      gnt = req[idx] ? NIN'(1) << idx : gnt;
    end
    valid = |req;
  end
endmodule

// File: rtl/fifo_arbiter_4x1.sv
// fifo_arbiter_4x1: round-robin merge of four input FIFOs into one output FIFO.
// Optional per-input grant counters are built when ARB_GRANT_CNT_EN is defined.
module fifo_arbiter_4x1
  import fifo_arbiter_4x1_pkg::*;
(
  input  logic               clk,
  input  logic               reset_L,
  input  logic               init,
  input  logic [TW-1:0]      umbral_sup_in,
  input  logic [TW-1:0]      umbral_inf_in,
  input  logic [NIN-1:0]     empty_in,
  input  logic [NIN*DW-1:0]  data_in,
  input  logic               almost_full_out,
  output logic [NIN-1:0]     pop,
  output logic               push,
  output logic [DW-1:0]      data_out,
  output logic [TW-1:0]      umbral_superior,
  output logic [TW-1:0]      umbral_inferior,
  output logic [3:0]         state,
  output logic               idle,
  output logic [31:0]        grant_cnt
);
  state_t         state_q, state_d;
  logic [NIN-1:0] req, gnt;
  logic           valid, grant, pend_q;
  logic [1:0]     gidx, gidx_q, rr_ptr_q;
  logic [DW-1:0]  dout_q;
  logic [TW-1:0]  sup_q, inf_q;
  assign req = ~empty_in;
  rr_select_4 u_sel (.req(req), .ptr(rr_ptr_q), .gnt(gnt), .valid(valid));
  // pop is combinational so a FIFO emptied by the last pop is never granted again
  assign grant    = reset_L && state_q == ST_ACTIVE && !almost_full_out && valid;
  assign gidx     = oh2idx(gnt);
  assign pop      = grant ? gnt : '0;
  assign push     = pend_q && reset_L;
  assign data_out = push ? data_in[DW*gidx_q +: DW] : dout_q;
  assign umbral_superior = sup_q;
  assign umbral_inferior = inf_q;
  assign state = state_q;
  assign idle  = state_q == ST_IDLE;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   state_d = init ? ST_INIT : ST_IDLE;
      ST_IDLE:   state_d = init ? ST_INIT : (|req ? ST_ACTIVE : ST_IDLE);
      ST_ACTIVE: state_d = init ? ST_INIT : (!(|req) && !pend_q ? ST_IDLE : ST_ACTIVE);
      default:   state_d = ST_RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= ST_RESET;
      pend_q   <= 1'b0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      dout_q   <= '0;
      sup_q    <= '0;
      inf_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= grant;
      if (grant) begin
        gidx_q   <= gidx;
        rr_ptr_q <= gidx + 2'd1;
      end
      if (push) dout_q <= data_out;
      if (state_q == ST_INIT) begin
        sup_q <= umbral_sup_in;
        inf_q <= umbral_inf_in;
      end
    end
  end
`ifdef ARB_GRANT_CNT_EN
  logic [7:0] cnt_q [NIN];
  always_ff @(posedge clk) begin
    if (!reset_L || state_d == ST_INIT) cnt_q <= '{default: '0};
    else if (grant) cnt_q[gidx] <= cnt_q[gidx] + 8'd1;
  end
  assign grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
  assign grant_cnt = '0;
`endif
endmodule
